// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states and the
// alignment/legality check applied before any data-memory request is issued.
package mem_stage_pkg;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } mem_state_t;

    // Stores have no unsigned variants, so funct3[2] set on a store is rejected too.
    function automatic logic access_fault(input logic       is_load,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic fault;
        case (funct3)
            F3_BYTE, F3_BYTE_U: fault = 1'b0;
            F3_HALF, F3_HALF_U: fault = addr_lo[0];
            F3_WORD:            fault = (addr_lo != 2'b00);
            default:            fault = 1'b1;
        endcase
        if (!is_load && funct3[2]) begin
            fault = 1'b1;
        end
        return fault;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables / replicated write data, and
// load byte/half extraction with sign or zero extension. No state, no backpressure.
module mem_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);
    import mem_stage_pkg::*;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        ld_byte  = ld_word[{addr_lo, 3'b000} +: 8];
        ld_half  = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase

        case (funct3)
            F3_BYTE:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BYTE_U: ld_data = {24'd0, ld_byte};
            F3_HALF:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HALF_U: ld_data = {16'd0, ld_half};
            default:   ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: 1-cycle ALU pass-through, stores >= 2 cycles, loads >= 3 cycles.
// Holds upstream via mem_stall while a data-memory request or response is outstanding.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ex_mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0]   ex_mem_rd,
    input  logic [DATA_WIDTH-1:0]       ex_mem_alu_result,
    input  logic [DATA_WIDTH-1:0]       ex_mem_rs2_data,
    input  logic                        ex_mem_reg_write,
    input  logic                        ex_mem_mem_read,
    input  logic                        ex_mem_mem_write,
    input  logic [2:0]                  ex_mem_funct3,
    output logic                        dmem_req_valid,
    input  logic                        dmem_req_ready,
    output logic [DATA_WIDTH-1:0]       dmem_addr,
    output logic                        dmem_we,
    output logic [DATA_WIDTH/8-1:0]     dmem_be,
    output logic [DATA_WIDTH-1:0]       dmem_wdata,
    input  logic                        dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]       dmem_rdata,
    output logic                        mem_stall,
    output logic                        mem_wb_valid,
    output logic [REG_ADDR_WIDTH-1:0]   mem_wb_rd,
    output logic                        mem_wb_reg_write,
    output logic [DATA_WIDTH-1:0]       mem_wb_result,
    output logic                        misalign_exc
);
    import mem_stage_pkg::*;

    mem_state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic [2:0]                  funct3_q, funct3_d;
    logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
    logic                        reg_write_q, reg_write_d;
    logic                        store_q, store_d;
    logic                        wb_valid_q, wb_valid_d;
    logic [REG_ADDR_WIDTH-1:0]   wb_rd_q, wb_rd_d;
    logic                        wb_reg_write_q, wb_reg_write_d;
    logic [DATA_WIDTH-1:0]       wb_result_q, wb_result_d;
    logic                        misalign_q, misalign_d;
    logic                        stall;
    logic                        is_mem, fault;
    logic [DATA_WIDTH/8-1:0]     align_be;
    logic [DATA_WIDTH-1:0]       align_wdata, align_ld;

    assign is_mem = ex_mem_mem_read | ex_mem_mem_write;
    assign fault  = access_fault(ex_mem_mem_read, ex_mem_funct3, ex_mem_alu_result[1:0]);

    mem_align u_align (
        .funct3   (funct3_q),
        .addr_lo  (addr_q[1:0]),
        .st_data  (data_q),
        .ld_word  (dmem_rdata),
        .st_be    (align_be),
        .st_wdata (align_wdata),
        .ld_data  (align_ld)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        store_d        = store_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        wb_result_d    = wb_result_q;
        misalign_d     = 1'b0;
        stall          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_mem_valid) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = ex_mem_rd;
                        wb_reg_write_d = ex_mem_reg_write & (ex_mem_rd != '0);
                        wb_result_d    = ex_mem_alu_result;
                    end else if (fault) begin
                        // Faulting address is reported in the result field.
                        wb_valid_d  = 1'b1;
                        wb_rd_d     = ex_mem_rd;
                        wb_result_d = ex_mem_alu_result;
                        misalign_d  = 1'b1;
                    end else begin
                        addr_d      = ex_mem_alu_result;
                        data_d      = ex_mem_rs2_data;
                        funct3_d    = ex_mem_funct3;
                        rd_d        = ex_mem_rd;
                        reg_write_d = ex_mem_reg_write;
                        store_d     = ex_mem_mem_write;
                        stall       = 1'b1;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall = !(store_q && dmem_req_ready);
                if (dmem_req_ready) begin
                    if (store_q) begin
                        wb_valid_d  = 1'b1;
                        wb_rd_d     = rd_q;
                        wb_result_d = addr_q;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = !dmem_rsp_valid;
                if (dmem_rsp_valid) begin
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = reg_write_q & (rd_q != '0);
                    wb_result_d    = align_ld;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            store_q        <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_result_q    <= '0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            store_q        <= store_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_result_q    <= wb_result_d;
            misalign_q     <= misalign_d;
        end
    end

    assign dmem_req_valid   = (state_q == S_REQ);
    assign dmem_addr        = dmem_req_valid ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem_we          = dmem_req_valid & store_q;
    assign dmem_be          = dmem_req_valid ? align_be : '0;
    assign dmem_wdata       = dmem_req_valid ? align_wdata : '0;
    assign mem_stall        = stall & ~rst_n;
    assign mem_wb_valid     = wb_valid_q;
    assign mem_wb_rd        = wb_rd_q;
    assign mem_wb_reg_write = wb_reg_write_q;
    assign mem_wb_result    = wb_result_q;
    assign misalign_exc     = misalign_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the RISC-V core. It sits between the EX/MEM register and the writeback stage, and it produces the MEM/WB register outputs, including `mem_wb_rd`. For RV32I loads and stores it runs a valid/ready data-memory transaction, aligning store data and byte enables and sign- or zero-extending load data. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: data and address width.
- `REG_ADDR_WIDTH`, default 5: destination register index width.

Ports:
- `clk`  in  1  single core clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-high reset.
- `ex_mem_valid`  in  1  EX/MEM holds a valid instruction.
- `ex_mem_rd`  in  5  destination register.
- `ex_mem_alu_result`  in  32  ALU result or effective address.
- `ex_mem_rs2_data`  in  32  store data.
- `ex_mem_reg_write`  in  1  instruction writes rd.
- `ex_mem_mem_read`  in  1  load.
- `ex_mem_mem_write`  in  1  store (never both with mem_read).
- `ex_mem_funct3`  in  3  access size/sign: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  memory accepts request.
- `dmem_addr`  out  32  word address, bits [1:0] = 0.
- `dmem_we`  out  1  1 = store.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-aligned store data.
- `dmem_rsp_valid`  in  1  load data valid.
- `dmem_rdata`  in  32  load word.
- `mem_stall`  out  1  hold EX/MEM and upstream.
- `mem_wb_valid`  out  1  MEM/WB holds a completed instruction.
- `mem_wb_rd`  out  5  destination register.
- `mem_wb_reg_write`  out  1  write enable; forced 0 when rd = 0.
- `mem_wb_result`  out  32  ALU result or formatted load data.
- `misalign_exc`  out  1  one-cycle pulse, registered with `mem_wb_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, valid non-memory op:
  - `mem_wb_*` load rd, reg_write and alu_result on the next edge.
  - `mem_wb_valid` = 1; no stall.
- IDLE, valid aligned memory op:
  - capture address, data, funct3 and rd into internal registers; go to REQ.
  - `mem_stall` = 1 combinationally in this cycle.
- REQ:
  - `dmem_req_valid` = 1; addr, we, be and wdata held stable until `dmem_req_ready`.
  - store handshake: complete; `mem_wb_valid` = 1, `mem_wb_reg_write` = 0; go to IDLE.
  - load handshake: go to WAIT.
- WAIT:
  - on `dmem_rsp_valid`: extract byte/half by address bits [1:0], sign- or zero-extend per funct3, write `mem_wb_*`, go to IDLE.
  - responses in IDLE or REQ are ignored.
- `mem_stall` = (IDLE & valid memory op) | (REQ & !(store & ready)) | WAIT & !rsp_valid. It drops in the completion cycle.
- Misaligned access (half with addr[0] = 1, word with addr[1:0] ≠ 0) or illegal load funct3 (011/110/111):
  - no memory request; no stall.
  - next edge: `mem_wb_valid` = 1, `mem_wb_reg_write` = 0, `misalign_exc` = 1, `mem_wb_rd` = rd.
- Store byte enables: SB → 0001 shifted by addr[1:0]; SH → 0011 or 1100; SW → 1111. wdata is replicated into the lanes.
- `mem_wb_valid` = 0 in any cycle with no completion.

## Timing
- Reset (synchronous): state IDLE; all outputs 0, including every `mem_wb_*`, `dmem_req_valid`, `mem_stall` and `misalign_exc`. Reset in REQ or WAIT abandons the transaction, and a late response is ignored.
- Non-memory op: 1-cycle latency.
- Store with ready held high: 2 cycles to `mem_wb_valid`.
- Load with ready high and response one cycle after the handshake: 3 cycles.
- A back-to-back memory op is accepted in the IDLE cycle after completion. No combinational path from `dmem_rdata` to `dmem_req_valid`.

## Structure
- Package `mem_stage_pkg`:
  - funct3 localparams
  - state enum `mem_state_t`
  - misalignment check function
- Sub-module `mem_align`: combinational store lane/byte-enable generation and load extract/extend.
- The FSM and MEM/WB registers live in the top module.

## Test plan
- ALU op rd = 7, result 0x1234 → next cycle `mem_wb_valid` = 1, `mem_wb_rd` = 7, `mem_wb_result` = 0x1234, no stall.
- SB addr 0x103, rs2 = 0xAB, ready held low 3 cycles → `dmem_addr` 0x100, `be` 1000, `wdata` 0xABABABAB stable throughout; `mem_stall` high until the handshake; `mem_wb_reg_write` = 0.
- LB addr 0x102, rdata 0x00800000 → result 0xFFFFFF80. LBU at the same address → 0x00000080.
- LW addr 0x102 → no request; `misalign_exc` pulse; `mem_wb_reg_write` = 0.
- Load to rd = 0 → `mem_wb_reg_write` = 0.
- Reset asserted in WAIT, response arrives afterwards → outputs 0, state IDLE, response ignored, no `mem_wb_valid`.
